// File: rtl/counter_pkg.sv
// Shared constants for the up/down limit counter family: mode encodings,
// default sizes and the prescaler phase-width helper.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEFAULT_N        = 8;
  localparam int DEFAULT_PRESCALE = 4;

  // A modulo-1 prescaler still needs a one-bit phase register to stay legal.
  function automatic int phase_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Modulo-PRESCALE request counter; o_step marks the request that completes a
// full prescale period. Used only when COUNTER_PRESCALER_EN is defined.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_req,
  output logic o_step
);

  localparam int              PW   = phase_width(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_phase;

  assign o_step = i_req && (r_phase == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_phase <= '0;
    end else if (i_req) begin
      r_phase <= o_step ? '0 : r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/updown_limit_counter.sv
// Up/down counter bounded to [i_min, i_max] with wrap or saturate at the limits.
// Optional request prescaler is compiled in with COUNTER_PRESCALER_EN.
module updown_limit_counter
  import counter_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ce,
  input  logic         i_we,
  input  logic [N-1:0] i_data,
  input  logic         i_count_up,
  input  logic         i_count_down,
  input  logic         i_mode,
  input  logic [N-1:0] i_min,
  input  logic [N-1:0] i_max,
  output logic [N-1:0] o_data,
  output logic         o_at_min,
  output logic         o_at_max,
  output logic         o_wrap,
  output logic         o_sat,
  output logic         o_cfg_err
);

  if (N < 2) begin : g_bad_n
    $error("updown_limit_counter: N must be at least 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_limit_counter: PRESCALE must be at least 1");
  end

  logic [N-1:0] r_data;
  logic         r_wrap;
  logic         r_sat;
  logic [N-1:0] w_data_nxt;
  logic         w_wrap_nxt;
  logic         w_sat_nxt;
  logic         w_cfg_err;
  logic         w_req;
  logic         w_valid_req;
  logic         w_step;

  function automatic logic [N-1:0] clamp(input logic [N-1:0] v,
                                         input logic [N-1:0] lo,
                                         input logic [N-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  assign w_cfg_err   = (i_min > i_max);
  assign w_req       = i_count_up ^ i_count_down;
  assign w_valid_req = i_ce && !w_cfg_err && !i_we && w_req;

`ifdef COUNTER_PRESCALER_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_ce && !w_cfg_err && i_we),
    .i_req   (w_valid_req),
    .o_step  (w_step)
  );
`else
  assign w_step = w_valid_req;
`endif

  // Limit compares happen before the +/-1, so the sum never overflows N bits.
  always_comb begin
    w_data_nxt = r_data;
    w_wrap_nxt = 1'b0;
    w_sat_nxt  = 1'b0;
    if (i_ce && !w_cfg_err) begin
      if (i_we) begin
        w_data_nxt = clamp(i_data, i_min, i_max);
      end else if (w_step) begin
        if ((r_data < i_min) || (r_data > i_max)) begin
          w_data_nxt = clamp(r_data, i_min, i_max);
        end else if (i_count_up) begin
          if (r_data == i_max) begin
            if (i_mode == MODE_WRAP) begin
              w_data_nxt = i_min;
              w_wrap_nxt = 1'b1;
            end else begin
              w_sat_nxt = 1'b1;
            end
          end else begin
            w_data_nxt = r_data + 1'b1;
          end
        end else begin
          if (r_data == i_min) begin
            if (i_mode == MODE_WRAP) begin
              w_data_nxt = i_max;
              w_wrap_nxt = 1'b1;
            end else begin
              w_sat_nxt = 1'b1;
            end
          end else begin
            w_data_nxt = r_data - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_data <= w_data_nxt;
      r_wrap <= w_wrap_nxt;
      r_sat  <= w_sat_nxt;
    end
  end

  assign o_data    = r_data;
  assign o_wrap    = r_wrap;
  assign o_sat     = r_sat;
  assign o_at_min  = (r_data == i_min);
  assign o_at_max  = (r_data == i_max);
  assign o_cfg_err = w_cfg_err;

endmodule

// File: tb/tb_updown_limit_counter.sv
// Vector-table bench for updown_limit_counter; each count step is expanded to
// PRESCALE requests when COUNTER_PRESCALER_EN is defined.
module tb_updown_limit_counter;
  import counter_pkg::*;

  localparam int N = 8;
`ifdef COUNTER_PRESCALER_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  typedef struct {
    logic         rst;
    logic         ce;
    logic         we;
    logic         up;
    logic         dn;
    logic         mode;
    logic [N-1:0] data;
    logic [N-1:0] mn;
    logic [N-1:0] mx;
    logic [N-1:0] exp_data;
    logic         exp_wrap;
    logic         exp_sat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, ce, we, up, dn, mode;
  logic [N-1:0] data, mn, mx;
  logic [N-1:0] o_data;
  logic         o_at_min, o_at_max, o_wrap, o_sat, o_cfg_err;

  vec_t         vecs[$];
  vec_t         sb[$];
  logic         cur_mode;
  logic [N-1:0] cur_min, cur_max, last_exp;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  updown_limit_counter #(.N(N), .PRESCALE(PS)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_ce         (ce),
    .i_we         (we),
    .i_data       (data),
    .i_count_up   (up),
    .i_count_down (dn),
    .i_mode       (mode),
    .i_min        (mn),
    .i_max        (mx),
    .o_data       (o_data),
    .o_at_min     (o_at_min),
    .o_at_max     (o_at_max),
    .o_wrap       (o_wrap),
    .o_sat        (o_sat),
    .o_cfg_err    (o_cfg_err)
  );

  task automatic v(input logic r, input logic c, input logic w, input logic u,
                   input logic d, input logic [N-1:0] dat, input logic [N-1:0] e,
                   input logic ew, input logic es);
    vec_t t;
    t.rst = r; t.ce = c; t.we = w; t.up = u; t.dn = d; t.mode = cur_mode;
    t.data = dat; t.mn = cur_min; t.mx = cur_max;
    t.exp_data = e; t.exp_wrap = ew; t.exp_sat = es;
    vecs.push_back(t);
    last_exp = e;
  endtask

  // One count step: PS-1 requests that only advance the prescaler, then the stepping one.
  task automatic st(input logic u, input logic d, input logic [N-1:0] e,
                    input logic ew, input logic es);
    repeat (PS - 1) v(1'b0, 1'b1, 1'b0, u, d, '0, last_exp, 1'b0, 1'b0);
    v(1'b0, 1'b1, 1'b0, u, d, '0, e, ew, es);
  endtask

  task automatic chk(input string nm, input int idx, input logic [N-1:0] got,
                     input logic [N-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s vec%0d got=%h want=%h", nm, idx, got, want);
    end
  endtask

  initial begin
    vec_t e;
    rst = 1'b1; ce = 1'b0; we = 1'b0; up = 1'b0; dn = 1'b0; mode = 1'b0;
    data = '0; mn = '0; mx = '0;
    cur_mode = MODE_WRAP; cur_min = 8'h10; cur_max = 8'h40; last_exp = '0;

    // reset and clamped loads
    v(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    v(0, 1, 1, 0, 0, 8'h2F, 8'h2F, 0, 0);
    v(0, 1, 1, 0, 0, 8'h80, 8'h40, 0, 0);
    // wrap up through max
    v(0, 1, 1, 0, 0, 8'h3E, 8'h3E, 0, 0);
    st(1, 0, 8'h3F, 0, 0);
    st(1, 0, 8'h40, 0, 0);
    st(1, 0, 8'h10, 1, 0);
    v(0, 1, 0, 0, 0, 8'h00, 8'h10, 0, 0);
    // saturate down at min
    cur_mode = MODE_SAT;
    v(0, 1, 1, 0, 0, 8'h11, 8'h11, 0, 0);
    st(0, 1, 8'h10, 0, 0);
    st(0, 1, 8'h10, 0, 1);
    st(0, 1, 8'h10, 0, 1);
    st(0, 1, 8'h10, 0, 1);
    v(0, 1, 0, 0, 0, 8'h00, 8'h10, 0, 0);
    // both requests, clock enable low, reset beats load
    v(0, 1, 1, 0, 0, 8'h20, 8'h20, 0, 0);
    v(0, 1, 0, 1, 1, 8'h00, 8'h20, 0, 0);
    v(0, 0, 0, 1, 0, 8'h00, 8'h20, 0, 0);
    v(0, 0, 1, 0, 0, 8'h33, 8'h20, 0, 0);
    v(1, 1, 1, 0, 0, 8'h30, 8'h00, 0, 0);
    // below-range step clamps to min without a pulse
    st(1, 0, 8'h10, 0, 0);
    // inverted limits block load and count
    cur_min = 8'h50;
    v(0, 1, 1, 0, 0, 8'h45, 8'h10, 0, 0);
    v(0, 1, 0, 1, 0, 8'h00, 8'h10, 0, 0);
    cur_min = 8'h10;
    v(0, 1, 1, 0, 0, 8'h25, 8'h25, 0, 0);
    st(0, 1, 8'h24, 0, 0);
    // max lowered below the count: clamp, then saturate
    cur_max = 8'h20;
    st(1, 0, 8'h20, 0, 0);
    st(1, 0, 8'h20, 0, 1);
    // down-wrap from min to max
    cur_mode = MODE_WRAP;
    v(0, 1, 1, 0, 0, 8'h00, 8'h10, 0, 0);
    st(0, 1, 8'h20, 1, 0);
    // single-value range: every step is a limit event
    cur_min = 8'h30; cur_max = 8'h30;
    v(0, 1, 1, 0, 0, 8'h30, 8'h30, 0, 0);
    st(1, 0, 8'h30, 1, 0);
    st(0, 1, 8'h30, 1, 0);
    cur_mode = MODE_SAT;
    st(1, 0, 8'h30, 0, 1);
`ifdef COUNTER_PRESCALER_EN
    // phase counting, load clears phase, reset clears phase
    cur_mode = MODE_WRAP; cur_min = 8'h10; cur_max = 8'h40;
    v(0, 1, 1, 0, 0, 8'h20, 8'h20, 0, 0);
    repeat (3) v(0, 1, 0, 1, 0, 8'h00, 8'h20, 0, 0);
    v(0, 1, 0, 1, 0, 8'h00, 8'h21, 0, 0);
    repeat (3) v(0, 1, 0, 1, 0, 8'h00, 8'h21, 0, 0);
    v(0, 1, 0, 1, 0, 8'h00, 8'h22, 0, 0);
    repeat (2) v(0, 1, 0, 1, 0, 8'h00, 8'h22, 0, 0);
    v(0, 1, 1, 0, 0, 8'h20, 8'h20, 0, 0);
    repeat (3) v(0, 1, 0, 1, 0, 8'h00, 8'h20, 0, 0);
    v(0, 1, 0, 1, 0, 8'h00, 8'h21, 0, 0);
    repeat (2) v(0, 1, 0, 1, 0, 8'h00, 8'h21, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    repeat (3) v(0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0);
    v(0, 1, 0, 1, 0, 8'h00, 8'h10, 0, 0);
`endif

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst  = vecs[i].rst;  ce = vecs[i].ce;  we = vecs[i].we;
      up   = vecs[i].up;   dn = vecs[i].dn;  mode = vecs[i].mode;
      data = vecs[i].data; mn = vecs[i].mn;  mx = vecs[i].mx;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("data",    i, o_data, e.exp_data);
      chk("at_min",  i, N'(o_at_min),  N'(e.exp_data == e.mn));
      chk("at_max",  i, N'(o_at_max),  N'(e.exp_data == e.mx));
      chk("cfg_err", i, N'(o_cfg_err), N'(e.mn > e.mx));
      chk("wrap",    i, N'(o_wrap),    N'(e.exp_wrap));
      chk("sat",     i, N'(o_sat),     N'(e.exp_sat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
